// File: rtl/tlcf_phase_timer.sv
// tlcf_phase_timer: phase duration timer for the traffic-light controller.
// Loads a duration selected by the control word on start, counts it down in
// prescaled ticks, applies the accelerate clamp, and pulses expired once at
// the end of the phase.
module tlcf_phase_timer #(
  parameter int LONG_TIME  = 30,
  parameter int SHORT_TIME = 5,
  parameter int ACCEL_TIME = 2,
  parameter int TICK_DIV   = 50,
  parameter int CW         = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [1:0]    ctrl,
  input  logic          enable,
  output logic [CW-1:0] count,
  output logic          busy,
  output logic          expired
);

  localparam int PW = $clog2(TICK_DIV);

  localparam logic [CW-1:0] LONG_V  = CW'(LONG_TIME);
  localparam logic [CW-1:0] SHORT_V = CW'(SHORT_TIME);
  localparam logic [CW-1:0] ACCEL_V = CW'(ACCEL_TIME);
  localparam logic [CW-1:0] ONE_V   = CW'(1);
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [PW-1:0] pre;
  logic [PW-1:0] pre_nx;
  logic [CW-1:0] count_nx;
  logic          expired_nx;
  logic [CW-1:0] load;

  // busy is simply the registered state, so it carries no input path.
  assign busy = (state == RUN);

  // Select the phase duration: accelerate beats short, short beats long.
  always_comb begin
    load = LONG_V;
    if (ctrl[1]) begin
      load = ACCEL_V;
    end else if (ctrl[0]) begin
      load = SHORT_V;
    end else begin
      load = LONG_V;
    end
  end

  // Next-state logic: start reload, prescaled countdown, expiry and clamp.
  always_comb begin
    state_nx   = state;
    count_nx   = count;
    pre_nx     = pre;
    expired_nx = 1'b0;
    if (start) begin
      // Reload wins over everything, including a coincident final tick.
      state_nx = RUN;
      count_nx = load;
      pre_nx   = {PW{1'b0}};
    end else begin
      case (state)
        RUN: begin
          if (enable) begin
            if (pre != PRE_MAX) begin
              pre_nx = pre + 1'b1;
            end else begin
              pre_nx   = {PW{1'b0}};
              count_nx = count - 1'b1;
              if (count == ONE_V) begin
                state_nx   = IDLE;
                expired_nx = 1'b1;
              end else begin
                state_nx = RUN;
              end
            end
          end else begin
            pre_nx = pre;
          end
          // Clamp only fires while count > ACCEL_TIME (>= 2), so it can never
          // collide with the 1 -> 0 expiry decrement.
          if (ctrl[1] && (count > ACCEL_V)) begin
            count_nx = ACCEL_V;
          end else begin
            count_nx = count_nx;
          end
        end
        IDLE: begin
          count_nx = {CW{1'b0}};
          pre_nx   = {PW{1'b0}};
        end
        default: begin
          state_nx = IDLE;
          count_nx = {CW{1'b0}};
          pre_nx   = {PW{1'b0}};
        end
      endcase
    end
  end

  // State, count, prescaler and expiry pulse registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      count   <= {CW{1'b0}};
      pre     <= {PW{1'b0}};
      expired <= 1'b0;
    end else begin
      state   <= state_nx;
      count   <= count_nx;
      pre     <= pre_nx;
      expired <= expired_nx;
    end
  end

endmodule

// File: tb/tb_tlcf_phase_timer.sv
// Self-checking bench for tlcf_phase_timer with TICK_DIV=4, LONG=6, SHORT=3,
// ACCEL=2, CW=4: table of load cases, hand-written corner sequences and a
// randomized run against a remaining-time reference model.
module tb_tlcf_phase_timer;

  localparam int D  = 4;
  localparam int LT = 6;
  localparam int ST = 3;
  localparam int AT = 2;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [1:0]    ctrl;
  logic          enable;
  logic [CW-1:0] count;
  logic          busy;
  logic          expired;

  int n_pass = 0;
  int n_tot  = 0;

  // Reference model state: remaining enabled cycles in the phase.
  int  m_rem  = 0;
  bit  m_busy = 0;
  bit  m_exp  = 0;

  typedef struct {
    logic [1:0] c;
    int         ld;
    int         ee;
  } vec_t;

  vec_t vecs[4];

  tlcf_phase_timer #(
    .LONG_TIME (LT),
    .SHORT_TIME(ST),
    .ACCEL_TIME(AT),
    .TICK_DIV  (D),
    .CW        (CW)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .ctrl   (ctrl),
    .enable (enable),
    .count  (count),
    .busy   (busy),
    .expired(expired)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Advance the model by one edge using the inputs currently applied.
  task automatic model_step();
    int cnt;
    int pre;
    int pnew;
    if (!rst_n) begin
      m_rem = 0; m_busy = 0; m_exp = 0;
    end else if (start) begin
      m_rem  = (ctrl[1] ? AT : (ctrl[0] ? ST : LT)) * D;
      m_busy = 1; m_exp = 0;
    end else if (m_busy) begin
      cnt = (m_rem + D - 1) / D;
      pre = (D - (m_rem % D)) % D;
      m_exp = 0;
      if (ctrl[1] && cnt > AT) begin
        pnew  = enable ? (pre + 1) % D : pre;
        m_rem = AT * D - pnew;
      end else if (enable) begin
        m_rem = m_rem - 1;
        if (m_rem == 0) begin
          m_busy = 0; m_exp = 1;
        end
      end
    end else begin
      m_rem = 0; m_exp = 0;
    end
  endtask

  // From edge 'from', wait (bounded) for the expired pulse, expect it at 'ee'.
  task automatic run_to_expiry(input int from, input int ee, input int ld, input string nm);
    bit seen = 0;
    for (int k = from + 1; k <= from + 200 && !seen; k++) begin
      tick();
      if (ld > 0 && k % D == 0 && k < ee) chk({nm, "_count"}, count, ld - k / D);
      if (expired) begin
        seen = 1;
        chk({nm, "_exp_edge"}, k, ee);
        chk({nm, "_count0"}, count, 0);
        chk({nm, "_busy0"}, busy, 0);
      end
    end
    if (!seen) chk({nm, "_timeout"}, 0, 1);
    tick();
    chk({nm, "_pulse1cyc"}, expired, 0);
  endtask

  task automatic do_start(input logic [1:0] c);
    ctrl = c; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    bit   saw_exp;
    rst_n = 1'b0; start = 1'b1; ctrl = 2'b00; enable = 1'b1;

    vecs[0] = '{c: 2'b00, ld: 6, ee: 24};
    vecs[1] = '{c: 2'b01, ld: 3, ee: 12};
    vecs[2] = '{c: 2'b11, ld: 2, ee: 8};
    vecs[3] = '{c: 2'b10, ld: 2, ee: 8};

    // Reset held with start high.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_count", count, 0);
      chk("rst_busy", busy, 0);
      chk("rst_expired", expired, 0);
    end
    rst_n = 1'b1; start = 1'b0;
    tick();
    chk("post_rst_busy", busy, 0);
    chk("post_rst_count", count, 0);

    // Table of load cases.
    foreach (vecs[i]) begin
      do_start(vecs[i].c);
      chk("load_count", count, vecs[i].ld);
      chk("load_busy", busy, 1);
      run_to_expiry(0, vecs[i].ee, vecs[i].ld, "phase");
    end

    // Clamp raised between edges 5 and 6.
    do_start(2'b00);
    repeat (4) tick();
    chk("clamp_e4", count, 5);
    tick();
    ctrl = 2'b10;
    tick();
    chk("clamp_e6", count, 2);
    tick(); tick();
    chk("clamp_e8", count, 1);
    run_to_expiry(8, 12, 0, "clamp");
    ctrl = 2'b00;

    // Clamp raised when count is already 1: no effect.
    do_start(2'b00);
    repeat (20) tick();
    chk("noclamp_e20", count, 1);
    ctrl = 2'b10;
    tick();
    chk("noclamp_e21", count, 1);
    run_to_expiry(21, 24, 0, "noclamp");
    ctrl = 2'b00;

    // Enable low for 10 cycles mid-phase.
    do_start(2'b00);
    repeat (10) tick();
    chk("stall_e10", count, 4);
    enable = 1'b0;
    repeat (10) tick();
    chk("stall_hold", count, 4);
    enable = 1'b1;
    run_to_expiry(20, 34, 0, "stall");

    // Restart at the final edge suppresses expiry.
    do_start(2'b00);
    repeat (23) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_noexp", expired, 0);
    chk("restart_count", count, 6);
    chk("restart_busy", busy, 1);
    tick();
    chk("restart_noexp2", expired, 0);

    // Reset mid-phase: no expiry ever.
    do_start(2'b00);
    repeat (9) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst_count", count, 0);
    chk("midrst_busy", busy, 0);
    saw_exp = expired;
    repeat (30) begin
      tick();
      if (expired) saw_exp = 1;
    end
    chk("midrst_noexp", saw_exp, 0);

    // Randomized run against the model.
    m_rem = 0; m_busy = 0; m_exp = 0;
    for (int i = 0; i < 3000; i++) begin
      rst_n  = ($urandom_range(0, 199) != 0);
      start  = ($urandom_range(0, 24) == 0);
      enable = ($urandom_range(0, 7) != 0);
      ctrl   = {($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1))};
      model_step();
      tick();
      chk("rand_count", count, (m_rem + D - 1) / D);
      chk("rand_busy", busy, m_busy);
      chk("rand_expired", expired, m_exp);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/tlcf_phase_timer.md
# tlcf_phase_timer

Phase duration timer for the traffic-light controller. It sits directly downstream of the counter-control maker and consumes its 2-bit control word: bit 1 is the accelerate request and bit 0 is the short-phase select. On each start request it loads a phase duration, counts it down in prescaled "seconds", and pulses `expired` once when the phase ends. The light-sequencing FSM uses that pulse to advance to the next light.

## Interface
Parameters:
- `LONG_TIME`, default 30: ticks loaded for a normal long phase. Must be ≥1.
- `SHORT_TIME`, default 5: ticks loaded for a short phase. Must be ≥1.
- `ACCEL_TIME`, default 2: ticks loaded, or clamped to, on accelerate. Must be ≥1.
- `TICK_DIV`, default 50: clock cycles per tick. Must be ≥2.
- `CW`, default 6: count width. Must hold max(LONG_TIME, SHORT_TIME, ACCEL_TIME).

Ports:
- `clk`, input, 1: single clock. All state updates on the rising edge.
- `rst_n`, input, 1: reset. Synchronous, active-low.
- `start`, input, 1: load request, sampled on each edge. Level is not latched.
- `ctrl`, input, 2: control word from the counter-control maker. `ctrl[1]` = accelerate, `ctrl[0]` = short select.
- `enable`, input, 1: count enable. When low, the prescaler and the count freeze.
- `count`, output, CW: remaining ticks in the current phase.
- `busy`, output, 1: phase in progress.
- `expired`, output, 1: one-cycle pulse at the end of a phase.

## Operation
- Two states: IDLE (`busy`=0) and RUN (`busy`=1). An internal prescaler `pre` has width clog2(TICK_DIV).
- **Load value** is decided by priority:
  - `ctrl[1]`=1 → ACCEL_TIME.
  - Otherwise `ctrl[0]`=1 → SHORT_TIME.
  - Otherwise → LONG_TIME.
- **Start, any state:** `start`=1 at an edge sets `count`←load value, `pre`←0, `busy`←1, `expired`←0.
  - Start has priority over every other event, including reaching the final tick. When they coincide the timer reloads and `expired` does not pulse.
- **RUN with enable=1, no start:**
  - If `pre`≠TICK_DIV−1: `pre`←`pre`+1.
  - Otherwise: `pre`←0 and `count`←`count`−1.
- **Expiry:** the decrement that takes `count` from 1 to 0 also sets `busy`←0 and `expired`←1 on the same edge. The state becomes IDLE.
- **Accelerate clamp:** in RUN, with no start, if `ctrl[1]`=1 and `count`>ACCEL_TIME, then at the edge `count`←ACCEL_TIME.
  - `pre` is not reset by the clamp and continues normally.
  - The clamp overrides a coincident decrement.
  - If `count`≤ACCEL_TIME the clamp has no effect.
- **`ctrl` sampling:** `ctrl[0]` changes during RUN are ignored. `ctrl` is sampled only at start, and `ctrl[1]` is also sampled for the clamp.
- **IDLE:** `count` holds 0, `pre` holds 0, and `expired` is 0 except on the single expiry cycle.
- **Enable low in RUN:** `pre` and `count` hold. Start and clamp still act.
- **Arithmetic:** `count` never underflows. No decrement occurs at 0 because IDLE does not count.

## Timing
- **Reset** (`rst_n`=0 at an edge) sets `count`=0, `pre`=0, `busy`=0, `expired`=0. Reset overrides `start` and applies mid-phase with no expiry pulse.
- **Load latency:** `count` and `busy` are valid on the edge that samples `start`. Call this edge 0.
- **Expiry latency:** with enable held high and no clamp, decrements land at edges TICK_DIV, 2·TICK_DIV, … `expired`=1 for exactly the one cycle following edge N·TICK_DIV.
- **Enable stalls:** each enable-low cycle in RUN delays expiry by exactly one cycle.
- **Clamp latency:** clamp takes effect on the first edge where `ctrl[1]`=1 is sampled.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
Bench parameters: TICK_DIV=4, LONG_TIME=6, SHORT_TIME=3, ACCEL_TIME=2, CW=4.

1. **Reset:** hold `rst_n`=0 for 3 cycles with `start`=1 → `count`=0, `busy`=0, `expired`=0 throughout. Release → still idle.
2. **Long phase:** start with `ctrl`=00 → `count`=6 at edge 0, then 5 at edge 4 down to 0 at edge 24. `busy` falls at edge 24 and `expired`=1 for one cycle only.
3. **Short and accelerated loads:**
   - Start with `ctrl`=01 → `count`=3, expiry at edge 12.
   - Start with `ctrl`=11 → `count`=2, expiry at edge 8.
4. **Clamp:** start with `ctrl`=00 and raise `ctrl[1]` before edge 6 → `count`=5 at edge 4, 2 at edge 6, 1 at edge 8, 0 at edge 12 with the expired pulse.
   - Same run with `ctrl[1]` raised when `count`=1 → no change.
5. **Stall and restart:**
   - Drop `enable` for 10 cycles mid-phase of the `ctrl`=00 run → expiry at edge 34.
   - Re-pulse `start` at edge 24 of a separate run → no expired pulse, and `count`=6 again.
6. **Reset mid-phase:** `rst_n`=0 at edge 10 of a long phase → `count`=0, `busy`=0, and no expired pulse ever occurs.
